// File: rtl/dmem_port_arb_pkg.sv
// Shared definitions for the data-memory port arbiter: owner encoding,
// datapath widths and the bounded-wait counter update rule.
package dmem_port_arb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int MASK_W = 32;
    localparam int WAIT_W = 4;

    // Which port issued the access whose read response is in flight.
    localparam logic OWN_P0 = 1'b0;
    localparam logic OWN_P1 = 1'b1;

    // Next value of the port 1 wait counter. It only survives while port 1
    // keeps asking and keeps losing; a grant or a dropped request restarts it.
    function automatic logic [WAIT_W-1:0] wait_next(
        input logic [WAIT_W-1:0] cnt,
        input logic [WAIT_W-1:0] max_wait,
        input logic              p1_req,
        input logic              p1_gnt
    );
        logic [WAIT_W-1:0] nxt;
        nxt = cnt;
        if (!p1_req || p1_gnt) begin
            nxt = '0;
        end else if (cnt != max_wait) begin
            nxt = cnt + 1'b1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/dmem_port_arb.sv
// Arbiter for the single data-memory port. Port 0 (pipeline memory stage)
// normally wins; port 1 (DMA/debug) is forced through after MAX_WAIT lost
// cycles. Read responses (1-cycle latency) are steered back to their issuer.
module dmem_port_arb
    import dmem_port_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,

    input  logic              i_p0_req,
    input  logic              i_p0_wen,
    input  logic [ADDR_W-1:0] i_p0_addr,
    input  logic [DATA_W-1:0] i_p0_wdata,
    input  logic [MASK_W-1:0] i_p0_mask,
    output logic              o_p0_gnt,
    output logic              o_p0_stall,
    output logic              o_p0_rvld,
    output logic [DATA_W-1:0] o_p0_rdata,

    input  logic              i_p1_req,
    input  logic              i_p1_wen,
    input  logic [ADDR_W-1:0] i_p1_addr,
    input  logic [DATA_W-1:0] i_p1_wdata,
    input  logic [MASK_W-1:0] i_p1_mask,
    output logic              o_p1_gnt,
    output logic              o_p1_rvld,
    output logic [DATA_W-1:0] o_p1_rdata,

    output logic              o_mem_req,
    output logic              o_mem_wen,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [MASK_W-1:0] o_mem_mask,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt;
    logic              rsp_vld_p1;
    logic              rsp_own_p1;
    logic              force_p1;
    logic              p0_gnt;
    logic              p1_gnt;

    // Grant selection: starvation override first, then port 0, then port 1.
    always_comb begin
        force_p1 = i_p1_req && (wait_cnt == MAX_WAIT_C);
        p0_gnt   = 1'b0;
        p1_gnt   = 1'b0;
        if (!i_rst) begin
            if (force_p1) begin
                p1_gnt = 1'b1;
            end else if (i_p0_req) begin
                p0_gnt = 1'b1;
            end else if (i_p1_req) begin
                p1_gnt = 1'b1;
            end
        end
    end

    assign o_p0_gnt   = p0_gnt;
    assign o_p1_gnt   = p1_gnt;
    assign o_p0_stall = i_p0_req & ~p0_gnt;

    // Memory-side mux: mirror the granted port, drive all zeros when idle.
    always_comb begin
        o_mem_req   = 1'b0;
        o_mem_wen   = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_mask  = '0;
        if (p0_gnt) begin
            o_mem_req   = 1'b1;
            o_mem_wen   = i_p0_wen;
            o_mem_addr  = i_p0_addr;
            o_mem_wdata = i_p0_wdata;
            o_mem_mask  = i_p0_mask;
        end else if (p1_gnt) begin
            o_mem_req   = 1'b1;
            o_mem_wen   = i_p1_wen;
            o_mem_addr  = i_p1_addr;
            o_mem_wdata = i_p1_wdata;
            o_mem_mask  = i_p1_mask;
        end
    end

    // Request stage -> response stage: track the wait counter and which port
    // owns the read data arriving next cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wait_cnt   <= '0;
            rsp_vld_p1 <= 1'b0;
            rsp_own_p1 <= OWN_P0;
        end else begin
            wait_cnt   <= wait_next(wait_cnt, MAX_WAIT_C, i_p1_req, p1_gnt);
            rsp_vld_p1 <= (p0_gnt & ~i_p0_wen) | (p1_gnt & ~i_p1_wen);
            rsp_own_p1 <= p1_gnt ? OWN_P1 : OWN_P0;
        end
    end

    // A response landing while reset is asserted is discarded.
    assign o_p0_rvld  = rsp_vld_p1 & ~i_rst & (rsp_own_p1 == OWN_P0);
    assign o_p1_rvld  = rsp_vld_p1 & ~i_rst & (rsp_own_p1 == OWN_P1);

    // Read data fans out to both ports; rvld qualifies it.
    assign o_p0_rdata = i_mem_rdata;
    assign o_p1_rdata = i_mem_rdata;

endmodule

// File: tb/tb_dmem_port_arb.sv
// Directed bench for dmem_port_arb with MAX_WAIT=4.
module tb_dmem_port_arb;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_wen, p1_req, p1_wen;
    logic [31:0] p0_addr, p0_wdata, p0_mask;
    logic [31:0] p1_addr, p1_wdata, p1_mask;
    logic        p0_gnt, p0_stall, p0_rvld, p1_gnt, p1_rvld;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_req, mem_wen;
    logic [31:0] mem_addr, mem_wdata, mem_mask, mem_rdata;

    int total = 0;
    int bad   = 0;

    dmem_port_arb #(.MAX_WAIT(MW)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_p0_req   (p0_req),
        .i_p0_wen   (p0_wen),
        .i_p0_addr  (p0_addr),
        .i_p0_wdata (p0_wdata),
        .i_p0_mask  (p0_mask),
        .o_p0_gnt   (p0_gnt),
        .o_p0_stall (p0_stall),
        .o_p0_rvld  (p0_rvld),
        .o_p0_rdata (p0_rdata),
        .i_p1_req   (p1_req),
        .i_p1_wen   (p1_wen),
        .i_p1_addr  (p1_addr),
        .i_p1_wdata (p1_wdata),
        .i_p1_mask  (p1_mask),
        .o_p1_gnt   (p1_gnt),
        .o_p1_rvld  (p1_rvld),
        .o_p1_rdata (p1_rdata),
        .o_mem_req  (mem_req),
        .o_mem_wen  (mem_wen),
        .o_mem_addr (mem_addr),
        .o_mem_wdata(mem_wdata),
        .o_mem_mask (mem_mask),
        .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where new inputs are driven.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling (still far from the edge).
    task automatic settle();
        #2;
    endtask

    initial begin
        rst = 1'b1;
        p0_req = 1'b1; p0_wen = 1'b0; p0_addr = 32'hAAAA_0000; p0_wdata = 32'h0; p0_mask = 32'hFFFF_FFFF;
        p1_req = 1'b1; p1_wen = 1'b0; p1_addr = 32'hBBBB_0000; p1_wdata = 32'h0; p1_mask = 32'hFFFF_FFFF;
        mem_rdata = 32'h0;

        // Reset state: no grants, zeroed memory bus, stall follows p0 request
        cyc(); cyc(); settle();
        chk("rst_p0_gnt",   32'(p0_gnt),   32'd0);
        chk("rst_p1_gnt",   32'(p1_gnt),   32'd0);
        chk("rst_mem_req",  32'(mem_req),  32'd0);
        chk("rst_mem_wen",  32'(mem_wen),  32'd0);
        chk("rst_mem_addr", mem_addr,      32'd0);
        chk("rst_mem_mask", mem_mask,      32'd0);
        chk("rst_stall",    32'(p0_stall), 32'd1);
        chk("rst_p0_rvld",  32'(p0_rvld),  32'd0);
        chk("rst_p1_rvld",  32'(p1_rvld),  32'd0);

        // Idle after reset
        cyc(); rst = 1'b0; p0_req = 1'b0; p1_req = 1'b0; settle();
        chk("idle_mem_req",  32'(mem_req),  32'd0);
        chk("idle_mem_addr", mem_addr,      32'd0);
        chk("idle_stall",    32'(p0_stall), 32'd0);
        chk("idle_p0_rvld",  32'(p0_rvld),  32'd0);

        // Port 0 only read
        cyc(); p0_req = 1'b1; p0_wen = 1'b0; p0_addr = 32'h100; settle();
        chk("p0rd_gnt",      32'(p0_gnt),   32'd1);
        chk("p0rd_p1_gnt",   32'(p1_gnt),   32'd0);
        chk("p0rd_stall",    32'(p0_stall), 32'd0);
        chk("p0rd_mem_req",  32'(mem_req),  32'd1);
        chk("p0rd_mem_wen",  32'(mem_wen),  32'd0);
        chk("p0rd_mem_addr", mem_addr,      32'h100);
        cyc(); p0_req = 1'b0; mem_rdata = 32'hDEAD_BEEF; settle();
        chk("p0rd_rvld",     32'(p0_rvld),  32'd1);
        chk("p0rd_rdata",    p0_rdata,      32'hDEAD_BEEF);
        chk("p0rd_p1_rvld",  32'(p1_rvld),  32'd0);
        chk("p0rd_idle_req", 32'(mem_req),  32'd0);

        // Contention: p0 continuous, p1 reads 0x200; p1 forced on cycle 4
        cyc(); p0_req = 1'b1; p0_addr = 32'h400; p1_req = 1'b1; p1_wen = 1'b0; p1_addr = 32'h200;
        for (int i = 0; i < MW; i++) begin
            settle();
            chk($sformatf("cont_p0_gnt%0d", i), 32'(p0_gnt),   32'd1);
            chk($sformatf("cont_p1_gnt%0d", i), 32'(p1_gnt),   32'd0);
            chk($sformatf("cont_addr%0d", i),   mem_addr,      32'h400);
            cyc();
        end
        settle();
        chk("cont_force_p1_gnt", 32'(p1_gnt),   32'd1);
        chk("cont_force_p0_gnt", 32'(p0_gnt),   32'd0);
        chk("cont_force_stall",  32'(p0_stall), 32'd1);
        chk("cont_force_addr",   mem_addr,      32'h200);
        cyc(); p1_req = 1'b0; mem_rdata = 32'hCAFE_F00D; settle();
        chk("cont_p1_rvld",  32'(p1_rvld), 32'd1);
        chk("cont_p1_rdata", p1_rdata,     32'hCAFE_F00D);
        chk("cont_p0_rvld",  32'(p0_rvld), 32'd0);
        chk("cont_p0_again", 32'(p0_gnt),  32'd1);
        cyc(); p0_req = 1'b0; mem_rdata = 32'h0000_0400; settle();
        chk("cont_p0_rvld_last", 32'(p0_rvld), 32'd1);
        chk("cont_p1_rvld_last", 32'(p1_rvld), 32'd0);

        // Port 1 write, uncontended
        cyc(); p1_req = 1'b1; p1_wen = 1'b1; p1_addr = 32'h300; p1_wdata = 32'h1234_5678; p1_mask = 32'hFFFF_0000;
        settle();
        chk("p1wr_gnt",   32'(p1_gnt),  32'd1);
        chk("p1wr_wen",   32'(mem_wen), 32'd1);
        chk("p1wr_addr",  mem_addr,     32'h300);
        chk("p1wr_wdata", mem_wdata,    32'h1234_5678);
        chk("p1wr_mask",  mem_mask,     32'hFFFF_0000);
        cyc(); p1_req = 1'b0; p1_wen = 1'b0; p1_mask = 32'hFFFF_FFFF; settle();
        chk("p1wr_no_rvld0", 32'(p0_rvld), 32'd0);
        chk("p1wr_no_rvld1", 32'(p1_rvld), 32'd0);

        // Back-to-back alternating reads
        cyc(); p0_req = 1'b1; p0_addr = 32'h10; settle();
        chk("alt_p0_gnt", 32'(p0_gnt), 32'd1);
        cyc(); p0_req = 1'b0; p1_req = 1'b1; p1_addr = 32'h20; mem_rdata = 32'h1111_1111; settle();
        chk("alt_p0_rvld",  32'(p0_rvld), 32'd1);
        chk("alt_p0_rdata", p0_rdata,     32'h1111_1111);
        chk("alt_p1_gnt",   32'(p1_gnt),  32'd1);
        chk("alt_p1_addr",  mem_addr,     32'h20);
        chk("alt_p1_early", 32'(p1_rvld), 32'd0);
        cyc(); p1_req = 1'b0; mem_rdata = 32'h2222_2222; settle();
        chk("alt_p1_rvld",  32'(p1_rvld), 32'd1);
        chk("alt_p1_rdata", p1_rdata,     32'h2222_2222);
        chk("alt_p0_late",  32'(p0_rvld), 32'd0);

        // Reset mid-operation: p1 read granted, then reset drops the response
        cyc(); p1_req = 1'b1; p1_addr = 32'h500; settle();
        chk("mrst_p1_gnt", 32'(p1_gnt), 32'd1);
        cyc(); rst = 1'b1; p0_req = 1'b1; p0_addr = 32'h600; mem_rdata = 32'h5555_5555; settle();
        chk("mrst_p1_rvld",  32'(p1_rvld),  32'd0);
        chk("mrst_p0_gnt",   32'(p0_gnt),   32'd0);
        chk("mrst_p1_gnt2",  32'(p1_gnt),   32'd0);
        chk("mrst_mem_req",  32'(mem_req),  32'd0);
        chk("mrst_mem_addr", mem_addr,      32'd0);
        chk("mrst_stall",    32'(p0_stall), 32'd1);
        for (int i = 0; i < MW + 1; i++) cyc();
        rst = 1'b0; settle();
        chk("mrst_p0_wins", 32'(p0_gnt),  32'd1);
        chk("mrst_p1_lose", 32'(p1_gnt),  32'd0);
        chk("mrst_no_rvld", 32'(p1_rvld), 32'd0);
        for (int i = 1; i < MW; i++) begin
            cyc(); settle();
            chk($sformatf("mrst_p0_gnt%0d", i), 32'(p0_gnt), 32'd1);
        end
        cyc(); settle();
        chk("mrst_forced_p1", 32'(p1_gnt), 32'd1);

        // Port 1 drops after 2 lost cycles, then needs a full MAX_WAIT again
        cyc(); p1_req = 1'b0; settle();
        chk("drop_p0_a", 32'(p0_gnt), 32'd1);
        cyc(); p1_req = 1'b1; settle();
        chk("drop_lose0", 32'(p1_gnt), 32'd0);
        cyc(); settle();
        chk("drop_lose1", 32'(p1_gnt), 32'd0);
        cyc(); p1_req = 1'b0; settle();
        chk("drop_p0_b", 32'(p0_gnt), 32'd1);
        cyc(); p1_req = 1'b1;
        for (int i = 0; i < MW; i++) begin
            settle();
            chk($sformatf("rereq_lose%0d", i), 32'(p1_gnt), 32'd0);
            cyc();
        end
        settle();
        chk("rereq_forced_p1", 32'(p1_gnt),   32'd1);
        chk("rereq_stall",     32'(p0_stall), 32'd1);

        cyc(); p0_req = 1'b0; p1_req = 1'b0; settle();
        chk("end_mem_req", 32'(mem_req), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
